// File: rtl/lfsr5_chk_pkg.sv
// Shared types and the 5-bit Galois LFSR step function for the stream checker.
package lfsr5_chk_pkg;
   localparam int LFSR_W = 5;
   // Feedback of q[4] into bit 2 on top of the rotate
   localparam logic [LFSR_W-1:0] LFSR_TAP = 5'h04;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACQ    = 2'd1,
      LOCKED = 2'd2
   } state_e;

   function automatic logic [LFSR_W-1:0] lfsr5_next(input logic [LFSR_W-1:0] s);
      return {s[LFSR_W-2:0], s[LFSR_W-1]} ^ (s[LFSR_W-1] ? LFSR_TAP : '0);
   endfunction
endpackage

// File: rtl/lfsr5_predict.sv
// Registered LFSR predictor: load next(data), advance to next(pred), or hold.
module lfsr5_predict
   import lfsr5_chk_pkg::*;
(
   input  logic              clk_i,
   input  logic              rst_b_i,
   input  logic              load_i,
   input  logic              adv_i,
   input  logic [LFSR_W-1:0] data_i,
   output logic [LFSR_W-1:0] pred_o
);
   logic [LFSR_W-1:0] pred_q, pred_d;

   always_comb begin
      pred_d = pred_q;
      if (load_i)     pred_d = lfsr5_next(data_i);
      else if (adv_i) pred_d = lfsr5_next(pred_q);
   end

   always_ff @(posedge clk_i or negedge rst_b_i) begin
      if (!rst_b_i) pred_q <= '0;
      else          pred_q <= pred_d;
   end

   assign pred_o = pred_q;
endmodule

// File: rtl/lfsr5_stream_checker.sv
// BIST checker for the 5-bit LFSR: lock, per-sample mismatch, error count.
// Optional period measurement is built when LFSR_CHK_PERIOD_EN is defined.
module lfsr5_stream_checker
   import lfsr5_chk_pkg::*;
#(
   parameter int LOCK_MATCH = 4,
   parameter int ERR_THRESH = 3,
   parameter int CNT_W      = 8
) (
   input  logic             clk_i,
   input  logic             rst_b_i,
   input  logic             start_i,
   input  logic             in_valid_i,
   input  logic [4:0]       in_data_i,
   output logic             locked_o,
   output logic             err_o,
   output logic [CNT_W-1:0] err_cnt_o,
   output logic [CNT_W-1:0] period_o,
   output logic             period_vld_o
);
   localparam int MC_W = $clog2(LOCK_MATCH + 1);
   localparam int MS_W = $clog2(ERR_THRESH + 1);
   localparam logic [MC_W-1:0]  LOCK_M  = MC_W'(LOCK_MATCH);
   localparam logic [MS_W-1:0]  ERR_T   = MS_W'(ERR_THRESH);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   state_e            state_q, state_d;
   logic              first_q, first_d;
   logic [MC_W-1:0]   match_q, match_d;
   logic [MS_W-1:0]   miss_q, miss_d;
   logic              locked_q, locked_d;
   logic              err_q, err_d;
   logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
   logic              pred_load, pred_adv;
   logic [LFSR_W-1:0] pred;

   lfsr5_predict u_pred (
      .clk_i   (clk_i),
      .rst_b_i (rst_b_i),
      .load_i  (pred_load),
      .adv_i   (pred_adv),
      .data_i  (in_data_i),
      .pred_o  (pred)
   );

   always_comb begin
      state_d   = state_q;
      first_d   = first_q;
      match_d   = match_q;
      miss_d    = miss_q;
      locked_d  = locked_q;
      err_d     = 1'b0;
      err_cnt_d = err_cnt_q;
      pred_load = 1'b0;
      pred_adv  = 1'b0;
      if (start_i) begin
         // A sample arriving with start is taken as the first ACQ sample
         state_d   = ACQ;
         locked_d  = 1'b0;
         err_cnt_d = '0;
         match_d   = '0;
         miss_d    = '0;
         first_d   = !in_valid_i;
         pred_load = in_valid_i;
      end else if (in_valid_i) begin
         case (state_q)
            ACQ: begin
               pred_load = 1'b1;
               if (first_q) begin
                  first_d = 1'b0;
                  match_d = '0;
               end else if (in_data_i == pred && in_data_i != '0) begin
                  if (match_q == LOCK_M - 1'b1) begin
                     state_d  = LOCKED;
                     locked_d = 1'b1;
                     match_d  = '0;
                     miss_d   = '0;
                  end else begin
                     match_d = match_q + 1'b1;
                  end
               end else begin
                  match_d = '0;
               end
            end
            LOCKED: begin
               pred_adv = 1'b1;
               if (in_data_i != pred) begin
                  err_d     = 1'b1;
                  err_cnt_d = (err_cnt_q == CNT_MAX) ? CNT_MAX : err_cnt_q + 1'b1;
                  if (miss_q == ERR_T - 1'b1) begin
                     // Lost lock: resync on this sample as in ACQ
                     state_d   = ACQ;
                     locked_d  = 1'b0;
                     match_d   = '0;
                     miss_d    = '0;
                     first_d   = 1'b0;
                     pred_adv  = 1'b0;
                     pred_load = 1'b1;
                  end else begin
                     miss_d = miss_q + 1'b1;
                  end
               end else begin
                  miss_d = '0;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_b_i) begin
      if (!rst_b_i) begin
         state_q   <= IDLE;
         first_q   <= 1'b1;
         match_q   <= '0;
         miss_q    <= '0;
         locked_q  <= 1'b0;
         err_q     <= 1'b0;
         err_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         first_q   <= first_d;
         match_q   <= match_d;
         miss_q    <= miss_d;
         locked_q  <= locked_d;
         err_q     <= err_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   assign locked_o  = locked_q;
   assign err_o     = err_q;
   assign err_cnt_o = err_cnt_q;

`ifdef LFSR_CHK_PERIOD_EN
   logic [LFSR_W-1:0] ref_q, ref_d;
   logic [CNT_W-1:0]  per_cnt_q, per_cnt_d;
   logic [CNT_W-1:0]  period_q, period_d;
   logic              pvld_q, pvld_d;
   logic              lock_evt;

   assign lock_evt = !start_i && in_valid_i && state_q == ACQ && state_d == LOCKED;

   always_comb begin
      ref_d     = ref_q;
      per_cnt_d = per_cnt_q;
      period_d  = period_q;
      pvld_d    = 1'b0;
      if (start_i) begin
         per_cnt_d = '0;
         period_d  = '0;
      end else if (lock_evt) begin
         ref_d     = in_data_i;
         per_cnt_d = '0;
      end else if (in_valid_i && state_q == LOCKED) begin
         if (in_data_i == ref_q) begin
            period_d  = (per_cnt_q == CNT_MAX) ? CNT_MAX : per_cnt_q + 1'b1;
            pvld_d    = 1'b1;
            per_cnt_d = '0;
         end else begin
            per_cnt_d = (per_cnt_q == CNT_MAX) ? CNT_MAX : per_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_b_i) begin
      if (!rst_b_i) begin
         ref_q     <= '0;
         per_cnt_q <= '0;
         period_q  <= '0;
         pvld_q    <= 1'b0;
      end else begin
         ref_q     <= ref_d;
         per_cnt_q <= per_cnt_d;
         period_q  <= period_d;
         pvld_q    <= pvld_d;
      end
   end

   assign period_o     = period_q;
   assign period_vld_o = pvld_q;
`else
   assign period_o     = '0;
   assign period_vld_o = 1'b0;
`endif
endmodule

// File: tb/tb_lfsr5_stream_checker.sv
// Randomized bench for lfsr5_stream_checker against a sequence-table reference model.
module tb_lfsr5_stream_checker;
   logic       clk_i = 1'b0;
   logic       rst_b_i = 1'b0;
   logic       start_i = 1'b0;
   logic       in_valid_i = 1'b0;
   logic [4:0] in_data_i = '0;
   logic       locked_o, err_o, period_vld_o;
   logic [7:0] err_cnt_o, period_o;

`ifdef LFSR_CHK_PERIOD_EN
   localparam bit PER_EN = 1'b1;
`else
   localparam bit PER_EN = 1'b0;
`endif

   lfsr5_stream_checker dut (
      .clk_i(clk_i), .rst_b_i(rst_b_i), .start_i(start_i), .in_valid_i(in_valid_i),
      .in_data_i(in_data_i), .locked_o(locked_o), .err_o(err_o), .err_cnt_o(err_cnt_o),
      .period_o(period_o), .period_vld_o(period_vld_o)
   );

   always #5 clk_i = ~clk_i;

   int nchk = 0, nerr = 0;

   // Generator sequence as a table: seq[k] is the k-th state after 5'h1F
   logic [4:0] seq [31];
   int         pos [32];
   logic [4:0] g;

   function automatic logic [4:0] nxt(input logic [4:0] s);
      if (s == 5'h00) return 5'h00;
      return seq[(pos[s] + 1) % 31];
   endfunction

   // Reference model state
   int         mst;        // 0 idle, 1 acquiring, 2 locked
   bit         mfirst, mlock, e_err, e_pvld;
   logic [4:0] mpred, mref;
   int         mmatch, mmiss, mcnt, mper, mperiod;

   function automatic int sat(input int v);
      return (v > 255) ? 255 : v;
   endfunction

   task automatic model_reset();
      mst = 0; mfirst = 1; mlock = 0; e_err = 0; e_pvld = 0; mpred = 0; mref = 0;
      mmatch = 0; mmiss = 0; mcnt = 0; mper = 0; mperiod = 0;
   endtask

   task automatic model_step(input bit st, input bit v, input logic [4:0] d);
      e_err = 0; e_pvld = 0;
      if (st) begin
         mst = 1; mlock = 0; mcnt = 0; mmatch = 0; mmiss = 0; mper = 0; mperiod = 0;
         mfirst = !v;
         if (v) mpred = nxt(d);
      end else if (v && mst == 1) begin
         if (mfirst) mfirst = 0;
         else if (d == mpred && d != 0) mmatch++;
         else mmatch = 0;
         mpred = nxt(d);
         if (mmatch == 4) begin
            mst = 2; mlock = 1; mref = d; mper = 0; mmatch = 0; mmiss = 0;
         end
      end else if (v && mst == 2) begin
         if (d == mref) begin mperiod = sat(mper + 1); e_pvld = 1; mper = 0; end
         else mper = sat(mper + 1);
         if (d != mpred) begin
            e_err = 1; mcnt = sat(mcnt + 1); mmiss++;
            if (mmiss == 3) begin
               mst = 1; mlock = 0; mmatch = 0; mmiss = 0; mpred = nxt(d);
            end else mpred = nxt(mpred);
         end else begin
            mmiss = 0; mpred = nxt(mpred);
         end
      end
      if (!PER_EN) begin e_pvld = 0; end
   endtask

   task automatic step(input bit st, input bit v, input logic [4:0] d);
      @(negedge clk_i);
      start_i = st; in_valid_i = v; in_data_i = d;
      @(posedge clk_i); #1;
      model_step(st, v, d);
      start_i = 0; in_valid_i = 0;
   endtask

   task automatic clean(input int n);
      for (int i = 0; i < n; i++) begin step(0, 1, g); g = nxt(g); end
   endtask

   task automatic test_reset();
      #3;
      nchk++;
      if ({locked_o, err_o, err_cnt_o, period_o, period_vld_o} !== '0) begin
         nerr++; $display("FAIL reset_state: got %b%b %0d %0d %b, want all 0",
                          locked_o, err_o, err_cnt_o, period_o, period_vld_o);
      end
      #9 rst_b_i = 1'b1;
      model_reset();
   endtask

   task automatic test_lock();
      g = 5'h1F;
      step(1, 0, 5'h00);
      for (int i = 0; i < 5; i++) begin
         step(0, 1, g); g = nxt(g);
         nchk++;
         if (locked_o !== (i == 4) || err_cnt_o !== 8'd0) begin
            nerr++; $display("FAIL lock_seq[%0d]: locked=%b err_cnt=%0d, want locked=%b err_cnt=0",
                             i, locked_o, err_cnt_o, (i == 4));
         end
      end
   endtask

   task automatic test_single_err();
      step(0, 1, g ^ 5'h04); g = nxt(g);
      nchk++;
      if (err_o !== 1'b1 || err_cnt_o !== 8'd1 || locked_o !== 1'b1) begin
         nerr++; $display("FAIL single_err: err=%b cnt=%0d locked=%b, want 1 1 1", err_o, err_cnt_o, locked_o);
      end
      step(0, 1, g); g = nxt(g);
      nchk++;
      if (err_o !== 1'b0 || err_cnt_o !== 8'd1 || locked_o !== 1'b1) begin
         nerr++; $display("FAIL single_err_after: err=%b cnt=%0d locked=%b, want 0 1 1", err_o, err_cnt_o, locked_o);
      end
   endtask

   task automatic test_drop_relock();
      step(1, 0, 5'h00);
      clean(5);
      for (int i = 0; i < 3; i++) begin
         step(0, 1, g ^ 5'($urandom_range(1, 31))); g = nxt(g);
      end
      nchk++;
      if (err_cnt_o !== 8'd3 || locked_o !== 1'b0) begin
         nerr++; $display("FAIL drop_lock: cnt=%0d locked=%b, want 3 0", err_cnt_o, locked_o);
      end
      for (int i = 0; i < 5; i++) begin
         step(0, 1, g); g = nxt(g);
         nchk++;
         if (locked_o !== (i == 4) || err_o !== 1'b0) begin
            nerr++; $display("FAIL relock[%0d]: locked=%b err=%b, want %b 0", i, locked_o, err_o, (i == 4));
         end
      end
   endtask

   task automatic test_period();
      int npv = 0;
      step(1, 0, 5'h00);
      clean(5);
      for (int i = 0; i < 70; i++) begin
         if ($urandom_range(0, 2) == 0) step(0, 0, 5'($urandom));
         step(0, 1, g); g = nxt(g);
         if (period_vld_o) npv++;
         nchk++;
         if (period_vld_o !== e_pvld || period_o !== 8'(mperiod * PER_EN) ||
             (PER_EN && e_pvld && period_o !== 8'd31)) begin
            nerr++; $display("FAIL period[%0d]: vld=%b period=%0d, want vld=%b period=%0d",
                             i, period_vld_o, period_o, e_pvld, mperiod * PER_EN);
         end
      end
      nchk++;
      if (npv !== (PER_EN ? 2 : 0)) begin
         nerr++; $display("FAIL period_count: got %0d pulses, want %0d", npv, PER_EN ? 2 : 0);
      end
   endtask

   task automatic test_stuck_zero();
      step(1, 0, 5'h00);
      for (int i = 0; i < 20; i++) begin
         step(0, 1, 5'h00);
         nchk++;
         if (locked_o !== 1'b0 || err_o !== 1'b0) begin
            nerr++; $display("FAIL stuck_zero[%0d]: locked=%b err=%b, want 0 0", i, locked_o, err_o);
         end
      end
      g = 5'h13;
      step(1, 1, g); g = nxt(g);
      for (int i = 0; i < 4; i++) begin
         step(0, 1, g); g = nxt(g);
         nchk++;
         if (locked_o !== (i == 3)) begin
            nerr++; $display("FAIL start_with_valid[%0d]: locked=%b, want %b", i, locked_o, (i == 3));
         end
      end
   endtask

   task automatic test_saturate();
      step(1, 0, 5'h00);
      clean(5);
      for (int i = 0; i < 260; i++) begin
         step(0, 1, g ^ 5'h01); g = nxt(g);
         nchk++;
         if (err_o !== 1'b1 || err_cnt_o !== 8'(mcnt)) begin
            nerr++; $display("FAIL sat_err[%0d]: err=%b cnt=%0d, want 1 %0d", i, err_o, err_cnt_o, mcnt);
         end
         clean(1);
      end
      nchk++;
      if (err_cnt_o !== 8'd255 || locked_o !== 1'b1) begin
         nerr++; $display("FAIL sat_final: cnt=%0d locked=%b, want 255 1", err_cnt_o, locked_o);
      end
   endtask

   task automatic test_random();
      logic [4:0] d;
      bit st, v;
      for (int i = 0; i < 600; i++) begin
         st = ($urandom_range(0, 59) == 0);
         v  = ($urandom_range(0, 3) != 0);
         case ($urandom_range(0, 19))
            0:       d = 5'h00;
            1, 2:    d = g ^ 5'($urandom_range(1, 31));
            default: d = g;
         endcase
         step(st, v, d);
         if (v) g = nxt(g);
         nchk++;
         if (locked_o !== mlock || err_o !== e_err || err_cnt_o !== 8'(mcnt) ||
             period_vld_o !== e_pvld || period_o !== 8'(mperiod * PER_EN)) begin
            nerr++; $display("FAIL random[%0d]: got l=%b e=%b c=%0d pv=%b p=%0d want l=%b e=%b c=%0d pv=%b p=%0d",
                             i, locked_o, err_o, err_cnt_o, period_vld_o, period_o,
                             mlock, e_err, mcnt, e_pvld, mperiod * PER_EN);
         end
      end
   endtask

   task automatic test_reset_midstream();
      step(1, 0, 5'h00);
      clean(5);
      step(0, 1, g ^ 5'h02); g = nxt(g);
      @(negedge clk_i); #2;
      rst_b_i = 1'b0;
      #1;
      nchk++;
      if ({locked_o, err_o, err_cnt_o, period_o, period_vld_o} !== '0) begin
         nerr++; $display("FAIL reset_mid: got %b%b %0d %0d %b, want all 0",
                          locked_o, err_o, err_cnt_o, period_o, period_vld_o);
      end
      #24 rst_b_i = 1'b1;
      model_reset();
      for (int i = 0; i < 8; i++) begin
         step(0, 1, g); g = nxt(g);
         nchk++;
         if (locked_o !== 1'b0 || err_o !== 1'b0 || err_cnt_o !== 8'd0) begin
            nerr++; $display("FAIL idle_ignore[%0d]: locked=%b err=%b cnt=%0d, want 0 0 0",
                             i, locked_o, err_o, err_cnt_o);
         end
      end
   endtask

   initial begin
      logic [4:0] s;
      s = 5'h1F;
      for (int k = 0; k < 31; k++) begin
         seq[k] = s; pos[s] = k;
         s = ((5'(s << 1)) | 5'(s >> 4)) ^ (s[4] ? 5'h04 : 5'h00);
      end
      pos[0] = 0;
      g = 5'h1F;
      model_reset();
      test_reset();
      test_lock();
      test_single_err();
      test_drop_relock();
      test_period();
      test_stuck_zero();
      test_saturate();
      test_random();
      test_reset_midstream();
      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end
endmodule
